// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds and overflow/underflow pulses.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 512,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  generate
    if (DATA_W < 1) begin : g_bad_width
      $error("sync_fifo_param: DATA_W must be at least 1");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_mode
      $error("sync_fifo_param: FWFT must be 0 or 1");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic full_q, full_d;
  logic empty_q, empty_d;
  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  // Acceptance uses the registered flags, so a read of an empty FIFO can never
  // see the word being written on the same edge.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    wr_acc   = wr_en && !full_q;
    rd_acc   = rd_en && !empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= AF_C);
    almost_empty_d = (count_d <= AE_C);
    overflow_d     = wr_en && full_q;
    underflow_d    = rd_en && empty_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; clearing the pointers
  // and count makes old contents unreachable, and a reset would prevent RAM
  // inference.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Last popped word, shown on dout while the FIFO is empty.
      logic [DATA_W-1:0] hold_q, hold_d;

      always_comb begin
        hold_d = hold_q;
        if (rd_acc) hold_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or posedge srst) begin
        if (srst) hold_q <= '0;
        else      hold_q <= hold_d;
      end

      assign dout  = empty_q ? hold_q : mem_q[rd_ptr_q];
      assign valid = !empty_q;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q, dout_d;
      logic              valid_q, valid_d;

      always_comb begin
        dout_d  = dout_q;
        valid_d = rd_acc;
        if (rd_acc) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          dout_q  <= dout_d;
          valid_q <= valid_d;
        end
      end

      assign dout  = dout_q;
      assign valid = valid_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign data_count   = count_q;

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO implemented in plain RTL: configurable data width, depth, read mode (standard or first-word-fall-through) and programmable almost-full/almost-empty thresholds, with overflow/underflow reporting. It is the next-generation replacement for the fixed 8-bit × 512 vendor-IP FIFO in single-clock datapaths. It drops into the same positions with identical core port names and gives tool-independent, simulator-portable behaviour.

## Interface
- DATA_W, 8: data word width in bits, ≥1.
- DEPTH, 512: number of storage words; power of two, ≥4.
- FWFT, 0: read mode. 0 = standard (registered read). 1 = first-word-fall-through.
- AF_THRESH, DEPTH-4: almost_full asserts when count ≥ AF_THRESH. Legal range 1..DEPTH.
- AE_THRESH, 4: almost_empty asserts when count ≤ AE_THRESH. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; everything is rising-edge.
- srst  in  1  asynchronous, active-high reset.
- din  in  DATA_W  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request (standard) or head acknowledge (FWFT).
- dout  out  DATA_W  read data.
- valid  out  1  dout holds a freshly read word (see Operation).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- overflow  out  1  one-cycle pulse: previous-cycle write was rejected.
- underflow  out  1  one-cycle pulse: previous-cycle read was rejected.
- data_count  out  $clog2(DEPTH)+1  words currently stored.

## Operation
- Storage is a DEPTH×DATA_W array with wr_ptr and rd_ptr, each $clog2(DEPTH) bits, plus a count register of $clog2(DEPTH)+1 bits.
- Pointers wrap naturally from DEPTH-1 to 0.
- Acceptance is judged on the flag values present before the edge:
  - write accepted = wr_en & !full
  - read accepted = rd_en & !empty
- There is no pass-through. A write into an empty FIFO and a read in the same cycle: write accepted, read rejected.
- Count update:
  - write only: +1
  - read only: −1
  - both accepted: unchanged, both pointers advance.
- Simultaneous events at the boundaries:
  - full, wr_en=1, rd_en=1: read accepted, write dropped, overflow pulses; count becomes DEPTH-1.
  - empty, wr_en=1, rd_en=1: write accepted, underflow pulses; count becomes 1.
- Rejected requests never change pointers, storage or count.
- Standard mode (FWFT=0): on an accepted read, dout is loaded with mem[rd_ptr] at that edge. valid is 1 for exactly the following cycle. dout holds its value otherwise.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally whenever !empty.
  - valid = !empty.
  - An accepted rd_en pops the head. The next word (or a hold value if count reaches 0) appears on dout after that edge.
- All flags and data_count are registered. They are computed from next-count, so they change on the same edge as count, never combinationally from wr_en/rd_en.
- Reset is asynchronous and clears pointers and count. On reset assertion, outputs take these values immediately:
  - full=0, empty=1, almost_full=0, almost_empty=1
  - overflow=0, underflow=0, valid=0
  - data_count=0, dout=0
- Reset mid-operation discards all stored data. Memory contents are not cleared and are unobservable after reset.
- Illegal parameters (DEPTH not a power of two, thresholds out of range) fail elaboration.

## Timing
- Write → visible:
  - data_count increments and empty deasserts one cycle after the accepting edge.
  - In FWFT, dout shows the word in that same cycle.
- Standard read latency: 1 cycle from the accepting edge to dout/valid.
- FWFT read latency: 0 cycles. The head is presented while empty=0.
- overflow/underflow are asserted for the one cycle following the rejecting edge. Back-to-back rejections give a continuous high.
- Throughput: one write and one read per cycle sustained at any fill level except at the full and empty boundaries described in Operation.
- First cycle after srst deasserts: a write is accepted normally.

## Test plan
- Fill/drain, DATA_W=8, DEPTH=16, FWFT=0:
  - Write 0x00..0x0F on 16 consecutive cycles → full=1 and data_count=16 one cycle after the 16th write.
  - Read 16 → dout sequence 0x00..0x0F, each 1 cycle after rd_en with valid=1; empty=1 after the last read.
- Overflow/underflow:
  - Write with full=1 → overflow pulses 1 cycle, data_count stays 16.
  - Read with empty=1 → underflow pulses 1 cycle, dout unchanged.
- Simultaneous read/write:
  - Full + wr/rd → count 15, overflow=1.
  - Empty + wr/rd → count 1, underflow=1.
  - Mid-fill (count 8) wr/rd for 40 cycles → count stays 8 and pointers wrap; data order is preserved.
- Thresholds, AF_THRESH=12, AE_THRESH=3:
  - almost_empty deasserts when count goes 3→4.
  - almost_full asserts when count goes 11→12; both coincide with data_count.
- FWFT=1:
  - Write 0xA5 to an empty FIFO → next cycle empty=0, valid=1, dout=0xA5 with no rd_en.
  - Pulse rd_en → empty=1 next cycle.
- Async reset: assert srst between edges at count 9 → all outputs take their reset values before the next clock edge.
  - After release, write 0x3C and read it back → dout=0x3C, no stale data.
